aes_inv_key_sched: RTL

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_inv_key_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse key schedule:
// FSM state encoding, round constants and round count.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_XOR,
        S_SUB0,
        S_SUB1
    } state_t;

    // Index 0 is never used by the schedule
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Table is stored row-major, entry 0 in the leftmost byte.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: loads the round-10 key in 16-bit
// beats and streams round keys 10 down to 0, one step per 3 cycles.
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] key_in,
    input  logic        key_in_valid,
    output logic        key_in_ready,
    output logic [15:0] key_out,
    output logic        key_out_valid,
    input  logic        key_out_ready,
    output logic [3:0]  round,
    output logic        key_last,
    output logic        busy
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_beat;
    logic [3:0]  r_round;
    logic [7:0]  r_key [16];
    logic [7:0]  r_s0;
    logic [7:0]  r_s1;
    logic [7:0]  w_sb_in0;
    logic [7:0]  w_sb_in1;
    logic [7:0]  w_sb_out0;
    logic [7:0]  w_sb_out1;
    logic        w_beat_end;
    logic [3:0]  w_hi_idx;
    logic [3:0]  w_lo_idx;

    assign w_beat_end = (r_beat == 3'd7);
    assign w_hi_idx   = {r_beat, 1'b0};
    assign w_lo_idx   = {r_beat, 1'b1};

    assign key_in_ready  = (r_state == S_LOAD);
    assign key_out_valid = (r_state == S_EMIT);
    assign busy          = (r_state != S_IDLE);
    assign round         = r_round;
    assign key_last      = key_out_valid && (r_round == 4'd0) && w_beat_end;
    assign key_out       = key_out_valid ?
                           {r_key[w_hi_idx], r_key[w_lo_idx]} : 16'h0000;

    // RotWord(w3') byte order is k13,k14,k15,k12
    assign w_sb_in0 = (r_state == S_SUB1) ? r_key[15] : r_key[13];
    assign w_sb_in1 = (r_state == S_SUB1) ? r_key[12] : r_key[14];

    aes_sbox u_sbox0 (
        .i_byte (w_sb_in0),
        .o_byte (w_sb_out0)
    );

    aes_sbox u_sbox1 (
        .i_byte (w_sb_in1),
        .o_byte (w_sb_out1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_LOAD;
            S_LOAD: if (key_in_valid && w_beat_end) w_next = S_EMIT;
            S_EMIT: begin
                if (key_out_ready && w_beat_end) begin
                    w_next = (r_round == 4'd0) ? S_IDLE : S_XOR;
                end
            end
            S_XOR:  w_next = S_SUB0;
            S_SUB0: w_next = S_SUB1;
            S_SUB1: w_next = S_EMIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= 3'd0;
            r_round <= 4'd0;
            r_s0    <= 8'h00;
            r_s1    <= 8'h00;
            for (int i = 0; i < 16; i++) r_key[i] <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) r_beat <= 3'd0;
                end
                S_LOAD: begin
                    if (key_in_valid) begin
                        r_key[w_hi_idx] <= key_in[15:8];
                        r_key[w_lo_idx] <= key_in[7:0];
                        r_beat          <= r_beat + 3'd1;
                        if (w_beat_end) r_round <= 4'(NUM_ROUNDS);
                    end
                end
                S_EMIT: begin
                    if (key_out_ready) r_beat <= r_beat + 3'd1;
                end
                S_XOR: begin
                    // Non-blocking reads give the pre-update words
                    for (int i = 4; i < 16; i++) begin
                        r_key[i] <= r_key[i] ^ r_key[i-4];
                    end
                end
                S_SUB0: begin
                    r_s0 <= w_sb_out0;
                    r_s1 <= w_sb_out1;
                end
                S_SUB1: begin
                    r_key[0] <= r_key[0] ^ r_s0 ^ RCON[r_round];
                    r_key[1] <= r_key[1] ^ r_s1;
                    r_key[2] <= r_key[2] ^ w_sb_out0;
                    r_key[3] <= r_key[3] ^ w_sb_out1;
                    r_round  <= r_round - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
